// File: rtl/dynamic_tmr_if.sv
// Command-path bundle between the command receiver, the TMR controller and
// the motor driver. The master drives commands and sensors; the slave returns
// the conditioned command, fault flags and redundancy state.
interface dynamic_tmr_if;
  logic [3:0] speed_cmd_i;
  logic [3:0] dir_cmd_i;
  logic [1:0] mode;
  logic [3:0] err_rate;
  logic       f1;
  logic       f2;
  logic       b1;
  logic       b2;
  logic [3:0] speed_cmd_o;
  logic [3:0] dir_cmd_o;
  logic [2:0] fault;
  logic       state_o;

  modport master (
    output speed_cmd_i, dir_cmd_i, mode, err_rate, f1, f2, b1, b2,
    input  speed_cmd_o, dir_cmd_o, fault, state_o
  );

  modport slave (
    input  speed_cmd_i, dir_cmd_i, mode, err_rate, f1, f2, b1, b2,
    output speed_cmd_o, dir_cmd_o, fault, state_o
  );
endinterface

// File: rtl/dynamic_tmr.sv
// Dynamic TMR controller for the motor command path.
// Three identical conditioning replicas feed either a simplex selector
// (replica 0 only, replicas 1/2 held cleared) or a bitwise majority voter.
// A small FSM picks the redundancy level from link error rate and sensor risk.
// An LFSR-driven injector corrupts one replica's speed bit to model link noise.

// One conditioning replica: combinational command shaping plus its register.
// en=0 holds the register cleared (stands in for a gated-off replica).
module dynamic_tmr_replica (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [3:0] speed_i,
  input  logic [3:0] dir_i,
  input  logic [1:0] mode_i,
  input  logic [2:0] risk_i,
  input  logic       fwd_blk_i,
  input  logic       rev_blk_i,
  input  logic [3:0] flip_i,
  output logic [3:0] spd_o,
  output logic [3:0] dir_o
);
  logic [3:0] spd_d, spd_q;
  logic [3:0] dir_d, dir_q;

  // Shape speed/direction according to mode and obstacle risk.
  always_comb begin
    spd_d = 4'd0;
    dir_d = 4'd0;
    case (mode_i)
      2'd0: begin // Auto: throttle by risk, back off a blocked front
        case (risk_i)
          3'd0:    spd_d = speed_i;
          3'd1:    spd_d = speed_i >> 1;
          default: spd_d = 4'd0;
        endcase
        dir_d = (fwd_blk_i && !rev_blk_i) ? 4'b1000 : dir_i;
      end
      2'd1: begin // Hybrid: cap at 4 whenever anything is sensed
        spd_d = (risk_i == 3'd0 || speed_i < 4'd4) ? speed_i : 4'd4;
        dir_d = dir_i;
      end
      2'd2: begin // Manual: pass through
        spd_d = speed_i;
        dir_d = dir_i;
      end
      default: begin // Sleep: park
        spd_d = 4'd0;
        dir_d = 4'd0;
      end
    endcase
  end

  // Replica register; the injected flip lands on the speed input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spd_q <= 4'd0;
      dir_q <= 4'd0;
    end else if (!en_i) begin
      spd_q <= 4'd0;
      dir_q <= 4'd0;
    end else begin
      spd_q <= spd_d ^ flip_i;
      dir_q <= dir_d;
    end
  end

  assign spd_o = spd_q;
  assign dir_o = dir_q;
endmodule

module dynamic_tmr #(
  parameter int         ERR_TH = 8,
  parameter int         HOLD   = 4,
  parameter logic [7:0] SEED   = 8'hA5
) (
  input  logic          clk,
  input  logic          rst,
  dynamic_tmr_if.slave  bus
);
  localparam int         NREP      = 3;
  localparam int         HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [4:0] ERR_TH_W  = 5'(ERR_TH);

  typedef enum logic {SIMPLEX = 1'b0, TMR = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          fresh_q;           // replicas 1/2 were cleared last cycle
  logic [7:0]    lfsr_q, lfsr_d;

  logic [2:0]    risk;
  logic          fwd_blk, rev_blk, hi_err, trig, sleep;

  logic                      inj_hit;
  logic [NREP-1:0][3:0]      inj_mask;
  logic [NREP-1:0]           rep_en;
  logic [NREP-1:0][3:0]      rep_spd;
  logic [NREP-1:0][3:0]      rep_dir;

  logic [3:0] vote_spd, vote_dir;
  logic [3:0] out_spd_d, out_dir_d, out_spd_q, out_dir_q;
  logic [2:0] fault_d, fault_q;

  // Sensor and link condition decode (sensors are active low).
  assign risk    = {2'b00, ~bus.f1} + {2'b00, ~bus.f2} + {2'b00, ~bus.b1} + {2'b00, ~bus.b2};
  assign fwd_blk = ~bus.f1 & ~bus.f2;
  assign rev_blk = ~bus.b1 & ~bus.b2;
  assign hi_err  = {1'b0, bus.err_rate} >= ERR_TH_W;
  assign trig    = hi_err | (risk >= 3'd2);
  assign sleep   = (bus.mode == 2'd3);

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting left.
  assign lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign inj_hit = lfsr_q[3:0] < bus.err_rate;

  // Replicas 1/2 only run in TMR; replica 0 always runs.
  assign rep_en = {state_q == TMR, state_q == TMR, 1'b1};

  for (genvar r = 0; r < NREP; r++) begin : g_rep
    // lfsr[7:6]==3 selects no replica, so injection never reaches a fourth.
    assign inj_mask[r] = (inj_hit && lfsr_q[7:6] == 2'(r)) ? (4'b0001 << lfsr_q[5:4]) : 4'd0;

    dynamic_tmr_replica u_rep (
      .clk       (clk),
      .rst       (rst),
      .en_i      (rep_en[r]),
      .speed_i   (bus.speed_cmd_i),
      .dir_i     (bus.dir_cmd_i),
      .mode_i    (bus.mode),
      .risk_i    (risk),
      .fwd_blk_i (fwd_blk),
      .rev_blk_i (rev_blk),
      .flip_i    (inj_mask[r]),
      .spd_o     (rep_spd[r]),
      .dir_o     (rep_dir[r])
    );
  end

  // State, hold counter, entry mask and LFSR registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SIMPLEX;
      hold_q  <= '0;
      fresh_q <= 1'b1;
      lfsr_q  <= SEED;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      fresh_q <= (state_q == SIMPLEX);
      lfsr_q  <= lfsr_d;
    end
  end

  // Redundancy FSM: escalate on risk/error, relax after HOLD quiet cycles,
  // drop straight to simplex when the drive is put to sleep.
  always_comb begin
    state_d = state_q;
    hold_d  = '0;
    case (state_q)
      SIMPLEX: begin
        if (trig && !sleep) state_d = TMR;
      end
      TMR: begin
        if (sleep) begin
          state_d = SIMPLEX;
        end else if (!trig) begin
          if (hold_q == HOLD_LAST) state_d = SIMPLEX;
          else                     hold_d  = hold_q + 1'b1;
        end
      end
      default: state_d = SIMPLEX;
    endcase
  end

  // Bitwise 2-of-3 majority.
  assign vote_spd = (rep_spd[0] & rep_spd[1]) | (rep_spd[0] & rep_spd[2]) | (rep_spd[1] & rep_spd[2]);
  assign vote_dir = (rep_dir[0] & rep_dir[1]) | (rep_dir[0] & rep_dir[2]) | (rep_dir[1] & rep_dir[2]);

  // Output select: vote in settled TMR. On the first TMR cycle replicas 1/2
  // still hold their cleared value, so replica 0 is passed and faults masked.
  always_comb begin
    out_spd_d = rep_spd[0];
    out_dir_d = rep_dir[0];
    fault_d   = 3'd0;
    if (state_q == TMR && !fresh_q) begin
      out_spd_d = vote_spd;
      out_dir_d = vote_dir;
      for (int i = 0; i < NREP; i++)
        fault_d[i] = {rep_spd[i], rep_dir[i]} != {vote_spd, vote_dir};
    end
  end

  // Output register stage; fault stays aligned with the data it flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_spd_q <= 4'd0;
      out_dir_q <= 4'd0;
      fault_q   <= 3'd0;
    end else begin
      out_spd_q <= out_spd_d;
      out_dir_q <= out_dir_d;
      fault_q   <= fault_d;
    end
  end

  assign bus.speed_cmd_o = out_spd_q;
  assign bus.dir_cmd_o   = out_dir_q;
  assign bus.fault       = fault_q;
  assign bus.state_o     = (state_q == TMR);

  // Only one replica is ever corrupted per cycle, so at most one flag fires.
  a_fault_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(fault_q));
endmodule

// File: tb/tb_dynamic_tmr.sv
// Bench for dynamic_tmr: directed walk through the main scenarios followed by
// randomized traffic, all checked against a cycle-level behavioural model.
module tb_dynamic_tmr;
  localparam int HOLD = 4;
  localparam int ERR_TH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dynamic_tmr_if bus();

  dynamic_tmr #(.ERR_TH(ERR_TH), .HOLD(HOLD), .SEED(8'hA5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit [7:0] m_lfsr;
  bit       m_tmr;
  bit       m_prev_simplex;
  int       m_quiet;
  bit [3:0] m_spd [3];
  bit [3:0] m_dir [3];
  bit [3:0] m_ospd, m_odir;
  bit [2:0] m_fault;

  task automatic model_reset();
    m_lfsr = 8'hA5; m_tmr = 0; m_prev_simplex = 1; m_quiet = 0;
    for (int i = 0; i < 3; i++) begin m_spd[i] = 0; m_dir[i] = 0; end
    m_ospd = 0; m_odir = 0; m_fault = 0;
  endtask

  function automatic void shape(input bit [3:0] sp, input bit [3:0] dr, input bit [1:0] md,
                                input int rk, input bit fb, input bit rb,
                                output bit [3:0] s, output bit [3:0] d);
    case (md)
      2'd0: begin
        s = (rk == 0) ? sp : (rk == 1) ? sp / 2 : 4'd0;
        d = (fb && !rb) ? 4'd8 : dr;
      end
      2'd1: begin
        s = (rk == 0) ? sp : ((sp < 4) ? sp : 4'd4);
        d = dr;
      end
      2'd2: begin s = sp; d = dr; end
      default: begin s = 0; d = 0; end
    endcase
  endfunction

  // Advance the model across one rising edge using the inputs now on the bus.
  task automatic model_edge();
    bit [3:0] ns [3];
    bit [3:0] nd [3];
    bit [3:0] s, d, vs, vd;
    int rk, r;
    bit fb, rb, trig, nt;
    // outputs from the replica contents before this edge
    if (m_tmr && !m_prev_simplex) begin
      // only one replica can be corrupt, so word-level 2-of-3 is enough
      if ((m_spd[0] == m_spd[1] && m_dir[0] == m_dir[1]) ||
          (m_spd[0] == m_spd[2] && m_dir[0] == m_dir[2])) begin
        vs = m_spd[0]; vd = m_dir[0];
      end else begin
        vs = m_spd[1]; vd = m_dir[1];
      end
      for (int i = 0; i < 3; i++) m_fault[i] = (m_spd[i] != vs) || (m_dir[i] != vd);
      m_ospd = vs; m_odir = vd;
    end else begin
      m_ospd = m_spd[0]; m_odir = m_dir[0]; m_fault = 0;
    end
    // replicas
    rk = (!bus.f1) + (!bus.f2) + (!bus.b1) + (!bus.b2);
    fb = !bus.f1 && !bus.f2;
    rb = !bus.b1 && !bus.b2;
    shape(bus.speed_cmd_i, bus.dir_cmd_i, bus.mode, rk, fb, rb, s, d);
    for (int i = 0; i < 3; i++) begin ns[i] = s; nd[i] = d; end
    if (m_lfsr[3:0] < bus.err_rate) begin
      r = m_lfsr[7:6];
      if (r < 3) ns[r][m_lfsr[5:4]] = ~ns[r][m_lfsr[5:4]];
    end
    if (!m_tmr) for (int i = 1; i < 3; i++) begin ns[i] = 0; nd[i] = 0; end
    // redundancy state
    trig = (bus.err_rate >= ERR_TH) || (rk >= 2);
    nt = m_tmr;
    if (!m_tmr) begin
      if (trig && bus.mode != 3) nt = 1;
      m_quiet = 0;
    end else if (bus.mode == 3) begin
      nt = 0; m_quiet = 0;
    end else if (trig) begin
      m_quiet = 0;
    end else begin
      m_quiet++;
      if (m_quiet == HOLD) begin nt = 0; m_quiet = 0; end
    end
    m_prev_simplex = !m_tmr;
    m_tmr = nt;
    for (int i = 0; i < 3; i++) begin m_spd[i] = ns[i]; m_dir[i] = nd[i]; end
    m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
  endtask

  // ---------------- stimulus ----------------
  int fault_pulses = 0;

  // Drive one cycle of inputs ({f1,f2,b1,b2} = sens), clock it, compare.
  task automatic cycle(input bit [3:0] sp, input bit [3:0] dr, input bit [1:0] md,
                       input bit [3:0] er, input bit [3:0] sens);
    bus.speed_cmd_i = sp; bus.dir_cmd_i = dr; bus.mode = md; bus.err_rate = er;
    {bus.f1, bus.f2, bus.b1, bus.b2} = sens;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("spd",   bus.speed_cmd_o, m_ospd);
    check("dir",   bus.dir_cmd_o,   m_odir);
    check("fault", bus.fault,       m_fault);
    check("state", bus.state_o,     m_tmr);
    if (bus.fault != 0) fault_pulses++;
  endtask

  initial begin
    rst = 1'b1;
    bus.speed_cmd_i = 0; bus.dir_cmd_i = 0; bus.mode = 0; bus.err_rate = 0;
    {bus.f1, bus.f2, bus.b1, bus.b2} = 4'b1111;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_spd",   bus.speed_cmd_o, 0);
    check("rst_dir",   bus.dir_cmd_o,   0);
    check("rst_fault", bus.fault,       0);
    check("rst_state", bus.state_o,     0);
    rst = 1'b0;

    // manual pass-through, simplex
    repeat (2) cycle(4'd5, 4'd3, 2'd2, 4'd0, 4'b1111);
    check("t1_spd", bus.speed_cmd_o, 5);
    check("t1_dir", bus.dir_cmd_o, 3);

    // rear blocked (risk 2) escalates to TMR
    cycle(4'd5, 4'd3, 2'd0, 4'd0, 4'b1100);
    check("t2_state", bus.state_o, 1);
    repeat (2) cycle(4'd5, 4'd3, 2'd0, 4'd0, 4'b1100);
    check("t2_spd", bus.speed_cmd_o, 0);
    check("t2_fault", bus.fault, 0);

    // front blocked forces reverse
    repeat (3) cycle(4'd7, 4'd3, 2'd0, 4'd0, 4'b0011);
    check("t3_dir", bus.dir_cmd_o, 8);
    check("t3_spd", bus.speed_cmd_o, 0);
    check("t3_state", bus.state_o, 1);

    // risk 1 halves speed; HOLD quiet cycles return to simplex
    repeat (HOLD - 1) cycle(4'd6, 4'd2, 2'd0, 4'd0, 4'b1011);
    check("t4_hold_tmr", bus.state_o, 1);
    repeat (3) cycle(4'd6, 4'd2, 2'd0, 4'd0, 4'b1011);
    check("t4_spd", bus.speed_cmd_o, 3);
    check("t4_state", bus.state_o, 0);

    // high error rate: TMR with injected faults, vote holds the command
    for (int i = 0; i < 16; i++) begin
      cycle(4'd9, 4'd5, 2'd1, 4'd10, 4'b1111);
      if (i >= 2) check("t5_vote", bus.speed_cmd_o, 9);
    end
    check("t5_state", bus.state_o, 1);

    // sleep drops out of TMR at once and parks the outputs
    cycle(4'd9, 4'd5, 2'd3, 4'd0, 4'b1111);
    check("t6_state", bus.state_o, 0);
    cycle(4'd9, 4'd5, 2'd3, 4'd0, 4'b1111);
    check("t6_spd", bus.speed_cmd_o, 0);
    check("t6_fault", bus.fault, 0);

    // randomized traffic, with runs of held inputs so HOLD gets exercised
    for (int blk = 0; blk < 120; blk++) begin
      bit [3:0] sp, dr, er, sens;
      bit [1:0] md;
      int len;
      sp = 4'($urandom_range(0, 15));
      dr = 4'($urandom_range(0, 15));
      md = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      er = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      for (int b = 0; b < 4; b++) sens[b] = ($urandom_range(0, 3) != 0);
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) cycle(sp, dr, md, er, sens);
    end

    // asynchronous reset in mid-cycle
    cycle(4'd12, 4'd6, 2'd2, 4'd0, 4'b1111);
    cycle(4'd12, 4'd6, 2'd2, 4'd12, 4'b0000);
    #2 rst = 1'b1;
    #1;
    check("arst_spd",   bus.speed_cmd_o, 0);
    check("arst_dir",   bus.dir_cmd_o,   0);
    check("arst_fault", bus.fault,       0);
    check("arst_state", bus.state_o,     0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) cycle(4'd5, 4'd3, 2'd2, 4'd0, 4'b1111);
    check("post_rst_spd", bus.speed_cmd_o, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dynamic_tmr.md
# dynamic_tmr

Dynamic triple-modular-redundancy controller for a motor command path. It conditions incoming speed and direction commands with operation mode and four active-low proximity sensors. It runs the conditioning logic either as a single replica (simplex, low power) or as three replicas with a majority voter (TMR). The redundancy level is chosen at run time from the link error rate and sensor risk. It sits between the command receiver and the motor driver.

## Interface
- `ERR_TH`, default 8: `err_rate` threshold (≥) that forces TMR.
- `HOLD`, default 4: consecutive quiet cycles required before TMR→simplex.
- `SEED`, default 8'hA5: fault-injection LFSR reset value (nonzero).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `speed_cmd_i`  in  4  received speed command (unsigned).
- `dir_cmd_i`  in  4  received direction code.
- `mode`  in  2  operating mode: 0 Auto, 1 Hybrid, 2 Manual, 3 Sleep.
- `err_rate`  in  4  received-data error rate, 0–15.
- `f1`, `f2`  in  1 each  front sensors. Active low: 0 means an obstacle is detected.
- `b1`, `b2`  in  1 each  rear sensors, active low.
- `speed_cmd_o`  out  4  processed speed, registered.
- `dir_cmd_o`  out  4  processed direction, registered.
- `fault`  out  3  per-replica disagreement flags. Bit i covers replica i.
- `state_o`  out  1  redundancy state: 0 SIMPLEX, 1 TMR.

## Operation
- `risk` is the number of asserted sensors, i.e. the count of zeros among {f1,f2,b1,b2}, range 0–4.
- `fwd_blk` means f1=0 AND f2=0. `rev_blk` means b1=0 AND b2=0.
- Replica function. All three replicas are identical and compute (spd, dir) from the current inputs:
  - Manual: spd = speed_cmd_i; dir = dir_cmd_i.
  - Auto, risk=0: spd = speed_cmd_i.
  - Auto, risk=1: spd = speed_cmd_i>>1.
  - Auto, risk≥2: spd = 0.
  - Auto direction: dir = dir_cmd_i, except dir = 4'b1000 (reverse) when fwd_blk and not rev_blk.
  - Hybrid: spd = risk=0 ? speed_cmd_i : min(speed_cmd_i, 4); dir = dir_cmd_i.
  - Sleep: spd = 0, dir = 0.
- Each replica registers its (spd, dir) every cycle.
- Fault injector (models data corruption):
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1. Loaded with SEED on reset; advances every cycle.
  - If lfsr[3:0] < err_rate, replica r = lfsr[7:6] has bit lfsr[5:4] of its spd register inverted at that register's input.
  - r=3 means no injection. With err_rate=0 there is never any injection.
- State machine, two states:
  - SIMPLEX → TMR when (err_rate ≥ ERR_TH OR risk ≥ 2) AND mode≠Sleep.
  - TMR → SIMPLEX after HOLD consecutive cycles with err_rate < ERR_TH AND risk < 2.
  - TMR → SIMPLEX immediately when mode = Sleep.
- SIMPLEX behaviour:
  - Replicas 1 and 2 are held cleared (clock-gated equivalent).
  - Outputs take replica 0 directly; corruption passes undetected.
  - fault = 0.
- TMR behaviour:
  - Outputs are the bitwise majority of the three replicas.
  - fault[i] = 1 when replica i's {spd,dir} differs from the voted value.
  - At most one bit of fault is set per cycle.
- `state_o` is the registered state.

## Timing
- Reset values: all outputs 0, state SIMPLEX, replicas 0, LFSR = SEED.
- Latency: inputs sampled at edge N appear on speed_cmd_o/dir_cmd_o after edge N+1 (2-cycle pipeline). fault is aligned with the output it describes.
- State transition takes effect at the next edge. The voter/selector follows the registered state; the first TMR output appears 2 edges after the trigger.
- Replicas 1 and 2 entering TMR are cleared. Their first cycle is masked: fault is forced 0 for one cycle after entry.
- HOLD counter resets on any trigger condition. A mode change to Sleep overrides the counter.
- Asserting reset mid-operation clears everything immediately; there is no output glitch beyond the asynchronous clear.

## Test plan
- Reset 2 cycles, then mode=2, all sensors =1, err_rate=0, speed=5, dir=3 → after 2 cycles outputs 5/3, state_o=0, fault=0.
- Mode=0, sensors 4'b1100 (rear asserted, risk=2) → state_o=1 next cycle, speed_cmd_o=0, fault=0.
- Mode=0, sensors {f1,f2,b1,b2}=4'b0011 → dir_cmd_o=8, speed 0, TMR.
- Mode=0, sensors 4'b1011 (risk 1), speed=6 → speed_cmd_o=3. After HOLD cycles, state_o returns to 0.
- Mode=1, sensors 4'b1111, err_rate=10 → state_o=1. fault pulses on single bits matching the LFSR trace; voted speed stays equal to the command.
- Mode=3 while in TMR → state_o=0 next edge, outputs 0, fault 0. Rst mid-run → all outputs 0 asynchronously.
